// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - vector ALU issue sequencer: decode handshake, VRF read, ALU run, writeback, response
// Optional RUN watchdog enabled by defining VEC_SEQ_TIMEOUT_EN (adds parameter TIMEOUT_W).
module vec_alu_sequencer #(
    parameter int VLEN = 128
`ifdef VEC_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W = 8
`endif
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_opcode,
    input  logic [2:0]      req_op_type,
    input  logic [2:0]      req_vsew,
    input  logic [4:0]      req_vs1,
    input  logic [4:0]      req_vs2,
    input  logic [4:0]      req_vd,
    input  logic [31:0]     req_scalar,
    input  logic            flush,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [VLEN-1:0] rf_rdata1,
    input  logic [VLEN-1:0] rf_rdata2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [VLEN-1:0] rf_wdata,
    output logic            alu_run,
    output logic [5:0]      alu_opcode,
    output logic [2:0]      alu_vsew,
    output logic [2:0]      alu_op_type,
    output logic [VLEN-1:0] alu_vs1,
    output logic [VLEN-1:0] alu_vs2,
    input  logic            alu_done,
    input  logic [VLEN-1:0] alu_result,
    output logic            resp_valid,
    output logic            resp_err,
    input  logic            resp_ready,
    output logic            busy
);
    localparam int NCHUNK = VLEN / 64;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_RUN, S_WB, S_RSP} state_e;

    state_e          state_q;
    logic [5:0]      opcode_q;
    logic [2:0]      op_type_q;
    logic [2:0]      vsew_q;
    logic [4:0]      vd_q;
    logic [31:0]     scalar_q;
    logic            req_ready_q;
    logic            busy_q;
    logic            rf_we_q;
    logic            alu_run_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [4:0]      rf_raddr1_q;
    logic [4:0]      rf_raddr2_q;
    logic [4:0]      rf_waddr_q;
    logic [VLEN-1:0] rf_wdata_q;
    logic [VLEN-1:0] alu_vs1_q;
    logic [VLEN-1:0] alu_vs2_q;

    logic            req_bad;
    logic [31:0]     splat_src_d;
    logic [63:0]     splat_chunk_d;
    logic [VLEN-1:0] splat_d;

`ifdef VEC_SEQ_TIMEOUT_EN
    // Compared one step early so the counter hits all-ones on the edge that leaves RUN.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    logic [TIMEOUT_W-1:0] to_cnt_q;
`endif

    assign req_bad = (req_vsew > 3'd3) ||
                     !((req_op_type == 3'b001) || (req_op_type == 3'b010) || (req_op_type == 3'b100));

    // VI immediates are sign-extended to 32 bits first so one splat path serves VX and VI.
    always_comb begin
        splat_src_d = op_type_q[2] ? {{27{scalar_q[4]}}, scalar_q[4:0]} : scalar_q;
        case (vsew_q[1:0])
            2'd0:    splat_chunk_d = {8{splat_src_d[7:0]}};
            2'd1:    splat_chunk_d = {4{splat_src_d[15:0]}};
            2'd2:    splat_chunk_d = {2{splat_src_d[31:0]}};
            default: splat_chunk_d = {{32{splat_src_d[31]}}, splat_src_d};
        endcase
        splat_d = {NCHUNK{splat_chunk_d}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            op_type_q    <= '0;
            vsew_q       <= '0;
            vd_q         <= '0;
            scalar_q     <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rf_we_q      <= 1'b0;
            alu_run_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rf_raddr1_q  <= '0;
            rf_raddr2_q  <= '0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            alu_vs1_q    <= '0;
            alu_vs2_q    <= '0;
`ifdef VEC_SEQ_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        opcode_q    <= req_opcode;
                        op_type_q   <= req_op_type;
                        vsew_q      <= req_vsew;
                        vd_q        <= req_vd;
                        scalar_q    <= req_scalar;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_bad) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state_q      <= S_RSP;
                        end else begin
                            rf_raddr1_q <= req_vs1;
                            rf_raddr2_q <= req_vs2;
                            state_q     <= S_RD;
                        end
                    end
                end
                S_RD: state_q <= S_LAT;
                S_LAT: begin
                    alu_vs2_q <= rf_rdata2;
                    alu_vs1_q <= op_type_q[0] ? rf_rdata1 : splat_d;
                    alu_run_q <= 1'b1;
                    state_q   <= S_RUN;
`ifdef VEC_SEQ_TIMEOUT_EN
                    to_cnt_q  <= '0;
`endif
                end
                S_RUN: begin
                    if (alu_done) begin
                        rf_wdata_q <= alu_result;
                        rf_waddr_q <= vd_q;
                        rf_we_q    <= 1'b1;
                        alu_run_q  <= 1'b0;
                        state_q    <= S_WB;
                    end
`ifdef VEC_SEQ_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        alu_run_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= S_RSP;
                    end
                    to_cnt_q <= to_cnt_q + 1'b1;
`endif
                end
                S_WB: begin
                    rf_we_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    state_q      <= S_RSP;
                end
                S_RSP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Abort outranks every transition above, including a coincident alu_done.
            if (flush && (state_q != S_IDLE)) begin
                state_q      <= S_IDLE;
                alu_run_q    <= 1'b0;
                rf_we_q      <= 1'b0;
                resp_valid_q <= 1'b0;
                resp_err_q   <= 1'b0;
                req_ready_q  <= 1'b1;
                busy_q       <= 1'b0;
            end
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign rf_raddr1   = rf_raddr1_q;
    assign rf_raddr2   = rf_raddr2_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign alu_run     = alu_run_q;
    assign alu_opcode  = opcode_q;
    assign alu_vsew    = vsew_q;
    assign alu_op_type = op_type_q;
    assign alu_vs1     = alu_vs1_q;
    assign alu_vs2     = alu_vs2_q;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;

endmodule
